ir_prefetch: RTL and testbench

Instruction prefetch queue sitting directly upstream of the IR board. It issues sequential instruction-word fetches to the cache/memory port, buffers returned 36-bit words with their addresses, and presents the head word to IR, which captures it on CON.LOAD_IR. On a control transfer (jump, skip, interrupt, trap) the EBOX flushes the queue and redirects fetch, so IR never receives a word from the discarded stream.

---
 rtl/ir_prefetch_pkg.sv | 17 +
 rtl/pf_fifo.sv | 83 ++++++++
 rtl/ir_prefetch.sv | 115 +++++++++++
 tb/tb_ir_prefetch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ir_prefetch_pkg.sv
// Shared types and default sizing for the IR prefetch queue.
package ir_prefetch_pkg;

  localparam int PF_DEPTH   = 4;
  localparam int PF_MAX_OUT = 2;
  localparam int PF_VMA_W   = 18;
  localparam int WORD_W     = 36;

  // PDP-10 bit numbering: bit 0 is the most significant bit.
  typedef logic [0:WORD_W-1] tWord;

  typedef struct packed {
    tWord                  word;
    logic [PF_VMA_W-1:0]   pc;
  } t_entry;

endpackage

// File: rtl/pf_fifo.sv
// Synchronous FIFO holding prefetched words together with their fetch addresses.
module pf_fifo
  import ir_prefetch_pkg::*;
#(
  parameter int DEPTH = PF_DEPTH,
  parameter int PC_W  = PF_VMA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  tWord                         i_word,
  input  logic [PC_W-1:0]              i_pc,
  input  logic                         i_pop,
  output logic                         o_valid,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output tWord                         o_head_word,
  output logic [PC_W-1:0]              o_head_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  tWord            r_word [DEPTH];
  logic [PC_W-1:0] r_pc   [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;
  logic            w_full;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_valid = (r_count != '0);
  assign w_pop   = i_pop && o_valid && !i_clear;
  assign w_push  = i_push && !i_clear;

  // Entry storage: write at the tail on every accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_word[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_word[r_wr_ptr] <= i_word;
      r_pc[r_wr_ptr]   <= i_pc;
    end
  end

  // Pointer and occupancy tracking; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Head is forced to zero when empty so IR never sees stale data.
  always_comb begin
    o_head_word = '0;
    o_head_pc   = '0;
    if (o_valid) begin
      o_head_word = r_word[r_rd_ptr];
      o_head_pc   = r_pc[r_rd_ptr];
    end
  end

  assign o_count = r_count;

  // The request accounting upstream reserves a slot for every outstanding fetch.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(i_push && w_full));

endmodule

// File: rtl/ir_prefetch.sv
// Instruction prefetch queue: issues sequential fetches, drops returns from a
// flushed stream, and presents the head word and its PC to IR.
module ir_prefetch
  import ir_prefetch_pkg::*;
#(
  parameter int DEPTH   = PF_DEPTH,
  parameter int MAX_OUT = PF_MAX_OUT,
  parameter int VMA_W   = PF_VMA_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [VMA_W-1:0]             flushPC,
  output logic                         memReq,
  output logic [VMA_W-1:0]             memAddr,
  input  logic                         memAck,
  input  logic                         memValid,
  input  tWord                         memData,
  input  logic                         irLoad,
  output logic                         irValid,
  output tWord                         irWord,
  output logic [VMA_W-1:0]             irPC,
  output logic                         underrun,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [VMA_W-1:0] r_fetch_pc;
  logic             r_mem_req;
  logic [CW-1:0]    r_out;
  logic [CW-1:0]    r_drop;
  logic             r_underrun;

  logic             w_ack;
  logic             w_push;
  logic             w_pop;
  logic             w_fifo_valid;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_out_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic [CW:0]      w_sum_nxt;
  logic             w_req_nxt;

  assign w_ack = r_mem_req && memAck;

  // Next-cycle occupancy drives the registered request so that
  // queued words plus in-flight fetches never exceed the queue depth.
  always_comb begin
    w_push      = memValid && !flush && (r_drop == '0);
    w_pop       = irLoad && w_fifo_valid && !flush;
    w_out_nxt   = r_out + CW'(w_ack) - CW'(memValid);
    w_count_nxt = flush ? '0 : (w_count + CW'(w_push) - CW'(w_pop));
    w_sum_nxt   = {1'b0, w_count_nxt} + {1'b0, w_out_nxt};
    w_req_nxt   = (w_sum_nxt < (CW+1)'(DEPTH)) && (w_out_nxt < CW'(MAX_OUT));
  end

  // Fetch address, request, outstanding and discard accounting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= '0;
      r_mem_req  <= 1'b0;
      r_out      <= '0;
      r_drop     <= '0;
    end else begin
      r_mem_req <= w_req_nxt;
      r_out     <= w_out_nxt;
      if (flush) begin
        // Everything still in flight, including a request accepted right now,
        // belongs to the abandoned stream.
        r_fetch_pc <= flushPC;
        r_drop     <= w_out_nxt;
      end else begin
        if (w_ack) r_fetch_pc <= r_fetch_pc + VMA_W'(1);
        if (memValid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      end
    end
  end

  // Underrun flags a load attempted against an empty queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_underrun <= 1'b0;
    else        r_underrun <= irLoad && !w_fifo_valid && !flush;
  end

  pf_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (VMA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (flush),
    .i_push      (w_push),
    .i_word      (memData),
    .i_pc        (r_pc_tail()),
    .i_pop       (w_pop),
    .o_valid     (w_fifo_valid),
    .o_count     (w_count),
    .o_head_word (irWord),
    .o_head_pc   (irPC)
  );

  // Returns arrive in request order, so the tail PC is the oldest in-flight
  // address: fetchPC minus the number of fetches still outstanding.
  function automatic logic [VMA_W-1:0] r_pc_tail();
    return r_fetch_pc - VMA_W'(r_out);
  endfunction

  assign memReq   = r_mem_req;
  assign memAddr  = r_fetch_pc;
  assign irValid  = w_fifo_valid;
  assign underrun = r_underrun;
  assign count    = w_count;

endmodule

// File: tb/tb_ir_prefetch.sv
// Directed bench for ir_prefetch with an expected-word scoreboard.
module tb_ir_prefetch;
  import ir_prefetch_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [17:0]   flushPC;
  logic          memReq;
  logic [17:0]   memAddr;
  logic          memAck;
  logic          memValid;
  tWord          memData;
  logic          irLoad;
  logic          irValid;
  tWord          irWord;
  logic [17:0]   irPC;
  logic          underrun;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;
  bit ack_en = 0;
  bit ret_en = 0;

  t_entry        exp_q[$];
  logic [17:0]   pend[$];

  ir_prefetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .flushPC  (flushPC),
    .memReq   (memReq),
    .memAddr  (memAddr),
    .memAck   (memAck),
    .memValid (memValid),
    .memData  (memData),
    .irLoad   (irLoad),
    .irValid  (irValid),
    .irWord   (irWord),
    .irPC     (irPC),
    .underrun (underrun),
    .count    (count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [17:0] pc, input tWord w);
    t_entry e;
    e.pc   = pc;
    e.word = w;
    exp_q.push_back(e);
  endtask

  // Memory model: data word is 0o254000_000000 with the address in the low half.
  initial begin
    memAck   = 0;
    memValid = 0;
    memData  = '0;
    forever begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
        pend.delete();
        memAck   = 0;
        memValid = 0;
        memData  = '0;
      end else begin
        if (ret_en && pend.size() > 0) begin
          logic [17:0] a;
          a = pend.pop_front();
          memValid = 1;
          memData  = 36'o254000_000000 | {18'b0, a};
        end else begin
          memValid = 0;
          memData  = '0;
        end
        memAck = ack_en;
        if (memReq && memAck) pend.push_back(memAddr);
      end
    end
  end

  // Monitor: every word IR consumes is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && irValid && irLoad && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ir_pop: unexpected word irPC=%0o expected none", irPC);
        end else begin
          t_entry e;
          e = exp_q.pop_front();
          chk("ir_pc", {46'b0, irPC}, {46'b0, e.pc});
          chk("ir_word", {28'b0, irWord}, {28'b0, e.word});
        end
      end
    end
  end

  initial begin
    rst_n   = 0;
    flush   = 0;
    flushPC = '0;
    irLoad  = 0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_memReq", memReq, 0);
    chk("rst_memAddr", memAddr, 0);
    chk("rst_irValid", irValid, 0);
    chk("rst_irWord", irWord, 0);
    chk("rst_irPC", irPC, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_count", count, 0);

    tick();
    rst_n = 1;
    tick();
    @(negedge clk);
    chk("first_req", memReq, 1);
    chk("first_addr", memAddr, 0);

    // Flush to 0o1000 with the memory stalled
    tick();
    flushPC = 18'o1000;
    flush   = 1;
    tick();
    flush = 0;
    @(negedge clk);
    chk("flush_addr", memAddr, 18'o1000);
    chk("flush_req", memReq, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("stall_addr", memAddr, 18'o1000);
      chk("stall_count", count, 0);
    end

    // Fill to full
    for (int i = 0; i < 4; i++) expect_word(18'o1000 + 18'(i), 36'o254000_001000 + 36'(i));
    tick();
    ack_en = 1;
    ret_en = 1;
    repeat (12) tick();
    @(negedge clk);
    chk("full_count", count, 4);
    chk("full_req", memReq, 0);
    chk("full_addr", memAddr, 18'o1004);
    chk("full_head_pc", irPC, 18'o1000);
    chk("full_head_word", {28'b0, irWord}, {28'b0, 36'o254000_001000});

    // Drain, then one load against an empty queue
    tick();
    ack_en = 0;
    irLoad = 1;
    repeat (5) tick();
    irLoad = 0;
    @(negedge clk);
    chk("underrun_pulse", underrun, 1);
    chk("underrun_count", count, 0);
    tick();
    @(negedge clk);
    chk("underrun_clear", underrun, 0);

    // Two fetches in flight, then flush to 0o2000
    tick();
    ret_en = 0;
    ack_en = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("inflight_req", memReq, 0);
    tick();
    flushPC = 18'o2000;
    flush   = 1;
    tick();
    flush  = 0;
    ret_en = 1;
    @(negedge clk);
    chk("flush2_addr", memAddr, 18'o2000);
    chk("flush2_valid", irValid, 0);
    for (int i = 0; i < 4; i++) expect_word(18'o2000 + 18'(i), 36'o254000_002000 + 36'(i));
    repeat (12) tick();
    @(negedge clk);
    chk("flush2_count", count, 4);
    chk("flush2_head_pc", irPC, 18'o2000);
    tick();
    ack_en = 0;
    irLoad = 1;
    repeat (4) tick();
    irLoad = 0;
    @(negedge clk);
    chk("flush2_drained", count, 0);

    // Flush while a request is being accepted, landing near the address wrap
    tick();
    flushPC = 18'o777776;
    flush   = 1;
    ack_en  = 1;
    tick();
    flush = 0;
    @(negedge clk);
    chk("wrap_flush_addr", memAddr, 18'o777776);
    expect_word(18'o777776, 36'o254000_777776);
    expect_word(18'o777777, 36'o254000_777777);
    expect_word(18'o000000, 36'o254000_000000);
    expect_word(18'o000001, 36'o254000_000001);
    repeat (12) tick();
    @(negedge clk);
    chk("wrap_count", count, 4);
    chk("wrap_addr", memAddr, 18'o000002);
    chk("wrap_head_pc", irPC, 18'o777776);
    tick();
    ack_en = 0;
    irLoad = 1;
    repeat (4) tick();
    irLoad = 0;

    // Pop and return in the same cycle with one word queued
    tick();
    ret_en = 0;
    ack_en = 1;
    tick();
    tick();
    ack_en = 0;
    tick();
    expect_word(18'o2, 36'o254000_000002);
    expect_word(18'o3, 36'o254000_000003);
    ret_en = 1;
    tick();
    ret_en = 0;
    tick();
    @(negedge clk);
    chk("one_count", count, 1);
    chk("one_head_pc", irPC, 18'o2);
    tick();
    ret_en = 1;
    irLoad = 1;
    tick();
    ret_en = 0;
    irLoad = 0;
    @(negedge clk);
    chk("pushpop_count", count, 1);
    chk("pushpop_head_pc", irPC, 18'o3);

    // Reset with fetches in flight
    tick();
    ack_en = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("pre_rst_count", count, 1);
    tick();
    rst_n = 0;
    #1;
    chk("mid_rst_memReq", memReq, 0);
    chk("mid_rst_memAddr", memAddr, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_irValid", irValid, 0);
    chk("mid_rst_irPC", irPC, 0);
    exp_q.delete();
    ret_en = 1;
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 4; i++) expect_word(18'(i), 36'o254000_000000 + 36'(i));
    tick();
    @(negedge clk);
    chk("post_rst_req", memReq, 1);
    chk("post_rst_addr", memAddr, 0);
    repeat (12) tick();
    @(negedge clk);
    chk("post_rst_count", count, 4);
    tick();
    ack_en = 0;
    irLoad = 1;
    repeat (4) tick();
    irLoad = 0;
    tick();
    @(negedge clk);
    chk("final_count", count, 0);
    chk("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
